// File: rtl/elastic_fifo_pkg.sv
// Package for the elastic_fifo block: width helpers and wrap-around index math.
// Used by elastic_fifo and elastic_fifo_mem via import elastic_fifo_pkg::*.
package elastic_fifo_pkg;

  // Index width: one bit minimum, so a single-entry buffer still has a legal index.
  function automatic int idx_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Count width: wide enough to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance an index, wrapping from depth-1 back to 0. This is an explicit
  // compare rather than a modulo on a power-of-two pointer, so any depth works.
  function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned depth);
    return (idx == depth - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/elastic_fifo_mem.sv
// Storage for elastic_fifo: DEPTH x DIN register array.
// Ports:
//   clk            rising-edge clock
//   we/waddr/wdata synchronous write port
//   raddr/rdata    asynchronous (combinational) read port
module elastic_fifo_mem
  import elastic_fifo_pkg::*;
#(
  parameter  int DIN   = 16,
  parameter  int DEPTH = 2,
  localparam int IW    = idx_w(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [IW-1:0]  waddr,
  input  logic [DIN-1:0] wdata,
  input  logic [IW-1:0]  raddr,
  output logic [DIN-1:0] rdata
);

  logic [DIN-1:0] mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the count in the parent,
  // so clearing the array would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_fifo.sv
// elastic_fifo: valid/ready elastic buffer of arbitrary DEPTH with occupancy
// count and programmable almost-full / almost-empty flags. The head entry is
// presented combinationally from storage (first-word-fall-through), and both
// ready/valid outputs depend only on the registered count.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   din_valid/din_ready/din_data     producer side
//   dout_valid/dout_ready/dout_data  consumer side
//   occupancy                 entries held
//   almost_full/almost_empty  occupancy >= AFULL_THR / <= AEMPTY_THR
// Optional (macro ELASTIC_FIFO_WATERMARK_EN):
//   occ_max_clr               loads the current count into occ_max
//   occ_max                   registered high-water mark of occupancy
module elastic_fifo
  import elastic_fifo_pkg::*;
#(
  parameter  int DIN        = 16,
  parameter  int DEPTH      = 2,
  parameter  int AFULL_THR  = DEPTH - 1,
  parameter  int AEMPTY_THR = 1,
  localparam int CW         = cnt_w(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic [DIN-1:0] din_data,
  output logic           dout_valid,
  input  logic           dout_ready,
  output logic [DIN-1:0] dout_data,
  output logic [CW-1:0]  occupancy,
  output logic           almost_full,
  output logic           almost_empty
`ifdef ELASTIC_FIFO_WATERMARK_EN
  ,
  input  logic           occ_max_clr,
  output logic [CW-1:0]  occ_max
`endif
);

  localparam int            IW     = idx_w(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL_THR);
  localparam logic [CW-1:0] AE_C   = CW'(AEMPTY_THR);

  logic [IW-1:0] w_idx, r_idx;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  assign din_ready  = (count != FULL_C);
  assign dout_valid = (count != '0);
  assign push       = din_valid & din_ready;
  assign pop        = dout_valid & dout_ready;

  // NOTE: every output of this block gets a value on every path (default
  // first), so no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx <= '0;
      r_idx <= '0;
      count <= '0;
    end else begin
      if (push) w_idx <= IW'(idx_inc(32'(w_idx), 32'(DEPTH)));
      if (pop)  r_idx <= IW'(idx_inc(32'(r_idx), 32'(DEPTH)));
      count <= count_nxt;
    end
  end

  // A push sampled during reset is discarded, so the write is gated too.
  elastic_fifo_mem #(
    .DIN   (DIN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (w_idx),
    .wdata (din_data),
    .raddr (r_idx),
    .rdata (dout_data)
  );

  assign occupancy    = count;
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

`ifdef ELASTIC_FIFO_WATERMARK_EN
  // High-water mark tracks the post-update count; a clear reloads it with the
  // count currently held, and takes priority over the max update.
  always_ff @(posedge clk) begin
    if (rst)                    occ_max <= '0;
    else if (occ_max_clr)       occ_max <= count;
    else if (count_nxt > occ_max) occ_max <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_elastic_fifo.sv
// Self-checking bench for elastic_fifo. Three instances cover the depth-3,
// depth-5 and depth-4/threshold scenarios; a queue-based model checks every
// instance on every negative clock edge, and directed literals pin the model.
module tb_elastic_fifo;

  localparam int DEP [3] = '{3, 5, 4};
  localparam int AFT [3] = '{2, 4, 3};
  localparam int AET [3] = '{1, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, dv, dr, clr;
  logic [7:0] din [3];

  logic       rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic       af0, af1, af2, ae0, ae1, ae2;
  logic [7:0] dout0, dout1, dout2;
  logic [1:0] occ0;
  logic [2:0] occ1, occ2;
`ifdef ELASTIC_FIFO_WATERMARK_EN
  logic [1:0] om0;
  logic [2:0] om1, om2;
`endif

  elastic_fifo #(.DIN(8), .DEPTH(3)) u0 (
    .clk(clk), .rst(rst[0]), .din_valid(dv[0]), .din_ready(rdy0), .din_data(din[0]),
    .dout_valid(vld0), .dout_ready(dr[0]), .dout_data(dout0), .occupancy(occ0),
    .almost_full(af0), .almost_empty(ae0)
`ifdef ELASTIC_FIFO_WATERMARK_EN
    , .occ_max_clr(clr[0]), .occ_max(om0)
`endif
  );

  elastic_fifo #(.DIN(8), .DEPTH(5)) u1 (
    .clk(clk), .rst(rst[1]), .din_valid(dv[1]), .din_ready(rdy1), .din_data(din[1]),
    .dout_valid(vld1), .dout_ready(dr[1]), .dout_data(dout1), .occupancy(occ1),
    .almost_full(af1), .almost_empty(ae1)
`ifdef ELASTIC_FIFO_WATERMARK_EN
    , .occ_max_clr(clr[1]), .occ_max(om1)
`endif
  );

  elastic_fifo #(.DIN(8), .DEPTH(4), .AFULL_THR(3), .AEMPTY_THR(1)) u2 (
    .clk(clk), .rst(rst[2]), .din_valid(dv[2]), .din_ready(rdy2), .din_data(din[2]),
    .dout_valid(vld2), .dout_ready(dr[2]), .dout_data(dout2), .occupancy(occ2),
    .almost_full(af2), .almost_empty(ae2)
`ifdef ELASTIC_FIFO_WATERMARK_EN
    , .occ_max_clr(clr[2]), .occ_max(om2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each buffer is a bounded queue of words.
  logic [7:0] mq [3][$];
  bit         ok [3] = '{0, 0, 0};
  int         om_model = 0;

  function automatic int next_size(input int i);
    int s;
    s = mq[i].size();
    if (rst[i]) return 0;
    return s + ((dv[i] && s < DEP[i]) ? 1 : 0) - ((dr[i] && s > 0) ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    if (rst[2])      om_model <= 0;
    else if (clr[2]) om_model <= mq[2].size();
    else if (next_size(2) > om_model) om_model <= next_size(2);
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        mq[i].delete();
        ok[i] <= 1'b1;
      end else if (ok[i]) begin
        if (dv[i] && mq[i].size() < DEP[i]) begin
          if (dr[i] && mq[i].size() > 0) void'(mq[i].pop_front());
          mq[i].push_back(din[i]);
        end else if (dr[i] && mq[i].size() > 0) begin
          void'(mq[i].pop_front());
        end
      end
    end
  end

  task automatic cmp_one(input int i, input logic rdy, input logic vld, input int occ,
                         input logic af, input logic ae, input logic [7:0] d);
    int s;
    s = mq[i].size();
    check($sformatf("u%0d_din_ready", i),  32'(rdy), 32'(s < DEP[i]));
    check($sformatf("u%0d_dout_valid", i), 32'(vld), 32'(s > 0));
    check($sformatf("u%0d_occupancy", i),  32'(occ), 32'(s));
    check($sformatf("u%0d_almost_full", i),  32'(af), 32'(s >= AFT[i]));
    check($sformatf("u%0d_almost_empty", i), 32'(ae), 32'(s <= AET[i]));
    if (s > 0) check($sformatf("u%0d_dout_data", i), 32'(d), 32'(mq[i][0]));
  endtask

  always @(negedge clk) begin
    if (ok[0]) cmp_one(0, rdy0, vld0, int'(occ0), af0, ae0, dout0);
    if (ok[1]) cmp_one(1, rdy1, vld1, int'(occ1), af1, ae1, dout1);
    if (ok[2]) cmp_one(2, rdy2, vld2, int'(occ2), af2, ae2, dout2);
`ifdef ELASTIC_FIFO_WATERMARK_EN
    if (ok[2]) check("u2_occ_max", 32'(om2), 32'(om_model));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rx [$];
  logic [7:0] drain_exp [3] = '{8'h22, 8'h33, 8'h44};
  bit af_fill [4] = '{0, 0, 1, 1};
  bit ae_fill [4] = '{1, 0, 0, 0};
  bit af_drn  [4] = '{1, 0, 0, 0};
  bit ae_drn  [4] = '{0, 0, 1, 1};

  initial begin
    rst = 3'b111; dv = '0; dr = '0; clr = '0;
    din[0] = '0; din[1] = '0; din[2] = '0;
    step(); step();
    rst = '0;

    // Reset state on the depth-3 instance.
    check("rst_occ", 32'(occ0), 32'd0);
    check("rst_din_ready", 32'(rdy0), 32'd1);
    check("rst_dout_valid", 32'(vld0), 32'd0);
    check("rst_almost_empty", 32'(ae0), 32'd1);
    check("rst_almost_full", 32'(af0), 32'd0);

    // Fill depth 3 with the consumer stalled.
    dv[0] = 1'b1;
    din[0] = 8'h11; step(); check("fill_occ1", 32'(occ0), 32'd1);
    check("fill_head", 32'(dout0), 32'h11);
    din[0] = 8'h22; step(); check("fill_occ2", 32'(occ0), 32'd2);
    din[0] = 8'h33; step(); check("fill_occ3", 32'(occ0), 32'd3);
    check("full_not_ready", 32'(rdy0), 32'd0);
    din[0] = 8'h44; step();
    check("full_blocked_occ", 32'(occ0), 32'd3);
    check("full_head", 32'(dout0), 32'h11);

    // Pop while full: no push in that cycle, ready returns the cycle after.
    dr[0] = 1'b1; step(); dr[0] = 1'b0;
    check("pop_full_occ", 32'(occ0), 32'd2);
    check("pop_full_ready", 32'(rdy0), 32'd1);
    check("pop_full_head", 32'(dout0), 32'h22);
    step();
    check("late_push_occ", 32'(occ0), 32'd3);
    dv[0] = 1'b0;

    // Drain: 0x44 came from the wrapped write index.
    dr[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("drain_%0d", k), 32'(dout0), 32'(drain_exp[k]));
      step();
    end
    dr[0] = 1'b0;
    check("drain_empty_occ", 32'(occ0), 32'd0);
    check("drain_empty_valid", 32'(vld0), 32'd0);

    // Depth 5 streaming ramp.
    dv[1] = 1'b1; dr[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din[1] = 8'(i);
      if (vld1) rx.push_back(dout1);
      step();
      check($sformatf("stream_occ_%0d", i), 32'(occ1), 32'd1);
    end
    dv[1] = 1'b0;
    if (vld1) rx.push_back(dout1);
    step();
    dr[1] = 1'b0;
    check("stream_end_occ", 32'(occ1), 32'd0);
    check("stream_count", 32'(rx.size()), 32'd20);
    for (int k = 0; k < rx.size(); k++) check($sformatf("stream_word_%0d", k), 32'(rx[k]), 32'(k));

    // Depth 4 flags, thresholds 3 / 1.
    check("flag_af_0", 32'(af2), 32'd0);
    check("flag_ae_0", 32'(ae2), 32'd1);
    dv[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din[2] = 8'hA0 + 8'(k);
      step();
      check($sformatf("fill4_occ_%0d", k), 32'(occ2), 32'(k + 1));
      check($sformatf("fill4_af_%0d", k), 32'(af2), 32'(af_fill[k]));
      check($sformatf("fill4_ae_%0d", k), 32'(ae2), 32'(ae_fill[k]));
    end
    dv[2] = 1'b0;
    dr[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("drain4_occ_%0d", k), 32'(occ2), 32'(3 - k));
      check($sformatf("drain4_af_%0d", k), 32'(af2), 32'(af_drn[k]));
      check($sformatf("drain4_ae_%0d", k), 32'(ae2), 32'(ae_drn[k]));
    end
    dr[2] = 1'b0;

    // Reset mid-traffic with push and pop both requested.
    dv[2] = 1'b1;
    din[2] = 8'hB1; step();
    din[2] = 8'hB2; step();
    check("pre_rst_occ", 32'(occ2), 32'd2);
    rst[2] = 1'b1; din[2] = 8'hEE; dr[2] = 1'b1;
    step();
    rst[2] = 1'b0; dv[2] = 1'b0; dr[2] = 1'b0;
    check("post_rst_occ", 32'(occ2), 32'd0);
    check("post_rst_valid", 32'(vld2), 32'd0);
    check("post_rst_ready", 32'(rdy2), 32'd1);
    step();
    check("post_rst_still_empty", 32'(occ2), 32'd0);
    dv[2] = 1'b1; din[2] = 8'h5A; step(); dv[2] = 1'b0;
    check("post_rst_push_occ", 32'(occ2), 32'd1);
    check("post_rst_push_head", 32'(dout2), 32'h5A);
    dr[2] = 1'b1; step(); dr[2] = 1'b0;
    check("post_rst_pop_occ", 32'(occ2), 32'd0);

`ifdef ELASTIC_FIFO_WATERMARK_EN
    dv[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[2] = 8'hC0 + 8'(k);
      step();
    end
    dv[2] = 1'b0;
    dr[2] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    dr[2] = 1'b0;
    check("wm_occ_zero", 32'(occ2), 32'd0);
    check("wm_peak", 32'(om2), 32'd3);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    check("wm_cleared", 32'(om2), 32'd0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
